// File: rtl/useq_pkg.sv
// Shared definitions for the microcoded control sequencer: opcodes, FSM states
// and microword field-position helpers derived from the block parameters.
package useq_pkg;

  localparam logic [3:0] OP_NEXT = 4'd0;
  localparam logic [3:0] OP_JMP  = 4'd1;
  localparam logic [3:0] OP_JC   = 4'd2;
  localparam logic [3:0] OP_JNC  = 4'd3;
  localparam logic [3:0] OP_CALL = 4'd4;
  localparam logic [3:0] OP_RET  = 4'd5;
  localparam logic [3:0] OP_HALT = 4'd6;
  localparam logic [3:0] OP_LDC  = 4'd7;
  localparam logic [3:0] OP_DJNZ = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT,
    ST_FAULT
  } state_t;

  // The select field is never narrower than one bit, even for a single condition.
  function automatic int csel_width(input int num_cond);
    return (num_cond <= 2) ? 1 : $clog2(num_cond);
  endfunction

  function automatic int word_width(input int num_dctrl, input int num_cond, input int log_mem);
    return num_dctrl + 4 + csel_width(num_cond) + log_mem;
  endfunction

  function automatic int op_lsb(input int num_cond, input int log_mem);
    return log_mem + csel_width(num_cond);
  endfunction

  function automatic int dctrl_lsb(input int num_cond, input int log_mem);
    return op_lsb(num_cond, log_mem) + 4;
  endfunction

endpackage

// File: rtl/useq_stack.sv
// Return-address LIFO for the sequencer; pointer runs 0..P_DEPTH, with a
// synchronous active-low clear in addition to the block reset.
module useq_stack
  import useq_pkg::*;
#(
  parameter int P_DEPTH = 4,
  parameter int P_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               push,
  input  logic               pop,
  input  logic [P_WIDTH-1:0] push_data,
  output logic [P_WIDTH-1:0] top,
  output logic               full,
  output logic               empty
);

  localparam int PW = $clog2(P_DEPTH + 1);

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      ptr_dec;

  assign ptr_dec = ptr - 1'b1;
  assign full    = (ptr == PW'(P_DEPTH));
  assign empty   = (ptr == '0);
  assign top     = empty ? '0 : mem[ptr_dec];

  // Entries are not cleared; only the pointer decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst || !clr) begin
      ptr <= '0;
    end else if (push && !full) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr_dec;
    end
  end

endmodule

// File: rtl/useq_ctrl.sv
// Microcoded control sequencer with condition jumps, call/return, halt, fault
// detection and a microcode load port. Loop counter ops enabled by USEQ_LOOP_EN.
module useq_ctrl
  import useq_pkg::*;
#(
  parameter int P_LOG_MEMSIZE    = 4,
  parameter int P_NUM_D_CTRLBITS = 5,
  parameter int P_NUM_COND       = 4,
  parameter int P_STACK_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [P_NUM_COND-1:0]        cond,
  input  logic                         ld_we,
  input  logic [P_LOG_MEMSIZE-1:0]     ld_addr,
  input  logic [word_width(P_NUM_D_CTRLBITS, P_NUM_COND, P_LOG_MEMSIZE)-1:0] ld_data,
  output logic [P_NUM_D_CTRLBITS-1:0]  dp_ctrl,
  output logic [P_LOG_MEMSIZE-1:0]     upc,
  output logic                         busy,
  output logic                         halted,
  output logic                         fault
);

  localparam int CSW      = csel_width(P_NUM_COND);
  localparam int WW       = word_width(P_NUM_D_CTRLBITS, P_NUM_COND, P_LOG_MEMSIZE);
  localparam int OPL      = op_lsb(P_NUM_COND, P_LOG_MEMSIZE);
  localparam int DCL      = dctrl_lsb(P_NUM_COND, P_LOG_MEMSIZE);
  localparam int CEXT     = 2 ** CSW;
  localparam int MEMDEPTH = 2 ** P_LOG_MEMSIZE;

  state_t state;

  logic [WW-1:0]               imem [MEMDEPTH];
  logic [WW-1:0]               word;
  logic [P_NUM_D_CTRLBITS-1:0] dctrl;
  logic [3:0]                  op;
  logic [CSW-1:0]              csel;
  logic [P_LOG_MEMSIZE-1:0]    tgt;
  logic [P_LOG_MEMSIZE-1:0]    upc_inc;
  logic [CEXT-1:0]             cond_ext;
  logic                        cond_bit;

  logic                     stk_push;
  logic                     stk_pop;
  logic                     stk_clr;
  logic                     stk_full;
  logic                     stk_empty;
  logic [P_LOG_MEMSIZE-1:0] stk_top;

`ifdef USEQ_LOOP_EN
  logic [P_LOG_MEMSIZE-1:0] loop_cnt;
`endif

  // The store survives reset; a write landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst && ld_we && state != ST_RUN) begin
      imem[ld_addr] <= ld_data;
    end
  end

  assign word    = imem[upc];
  assign dctrl   = word[DCL +: P_NUM_D_CTRLBITS];
  assign op      = word[OPL +: 4];
  assign csel    = word[P_LOG_MEMSIZE +: CSW];
  assign tgt     = word[0 +: P_LOG_MEMSIZE];
  assign upc_inc = upc + 1'b1;

  // Selects beyond the implemented conditions read as zero.
  assign cond_ext = CEXT'(cond);
  assign cond_bit = cond_ext[csel];

  assign dp_ctrl = (state == ST_RUN) ? dctrl : '0;

  assign stk_push = (state == ST_RUN) && (op == OP_CALL) && !stk_full;
  assign stk_pop  = (state == ST_RUN) && (op == OP_RET) && !stk_empty;
  assign stk_clr  = !((state == ST_IDLE) && start);

  useq_stack #(
    .P_DEPTH (P_STACK_DEPTH),
    .P_WIDTH (P_LOG_MEMSIZE)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .clr       (stk_clr),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (upc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Faults change nothing but the state and status flags, so upc stays on the culprit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      upc    <= '0;
      busy   <= 1'b0;
      halted <= 1'b0;
      fault  <= 1'b0;
`ifdef USEQ_LOOP_EN
      loop_cnt <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            upc   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          case (op)
            OP_NEXT: upc <= upc_inc;
            OP_JMP:  upc <= tgt;
            OP_JC:   upc <= cond_bit ? tgt : upc_inc;
            OP_JNC:  upc <= cond_bit ? upc_inc : tgt;
            OP_CALL: begin
              if (stk_full) begin
                state <= ST_FAULT;
                busy  <= 1'b0;
                fault <= 1'b1;
              end else begin
                upc <= tgt;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                state <= ST_FAULT;
                busy  <= 1'b0;
                fault <= 1'b1;
              end else begin
                upc <= stk_top;
              end
            end
            OP_HALT: begin
              state  <= ST_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
`ifdef USEQ_LOOP_EN
            OP_LDC: begin
              loop_cnt <= tgt;
              upc      <= upc_inc;
            end
            OP_DJNZ: begin
              if (loop_cnt != '0) begin
                loop_cnt <= loop_cnt - 1'b1;
                upc      <= tgt;
              end else begin
                upc <= upc_inc;
              end
            end
`endif
            default: begin
              state <= ST_FAULT;
              busy  <= 1'b0;
              fault <= 1'b1;
            end
          endcase
        end
        ST_HALT, ST_FAULT: begin
          if (start) begin
            state  <= ST_IDLE;
            halted <= 1'b0;
            fault  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_useq_ctrl.sv
// Scoreboard bench for useq_ctrl: expected per-cycle outputs are queued as each
// program is started and compared cycle by cycle; USEQ_LOOP_EN selects the loop test.
module tb_useq_ctrl;
  import useq_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  cond;
  logic        ld_we;
  logic [3:0]  ld_addr;
  logic [14:0] ld_data;
  logic [4:0]  dp_ctrl;
  logic [3:0]  upc;
  logic        busy;
  logic        halted;
  logic        fault;

  useq_ctrl #(
    .P_LOG_MEMSIZE    (4),
    .P_NUM_D_CTRLBITS (5),
    .P_NUM_COND       (4),
    .P_STACK_DEPTH    (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cond    (cond),
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .dp_ctrl (dp_ctrl),
    .upc     (upc),
    .busy    (busy),
    .halted  (halted),
    .fault   (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] upc;
    logic [4:0] dp;
    logic       busy;
    logic       halted;
    logic       fault;
  } exp_t;

  exp_t        sb [$];
  logic [14:0] shadow [16];
  int          checkCount = 0;
  int          passCount  = 0;

  function automatic logic [14:0] mw(input int d, input logic [3:0] op, input int cs, input int tgt);
    return {5'(d), op, 2'(cs), 4'(tgt)};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Drives one clock's worth of control inputs, then returns everything to idle levels.
  task automatic applyStimulus(input logic s_start, input logic s_rst, input logic s_we,
                               input logic [3:0] a, input logic [14:0] d);
    start   = s_start;
    rst     = s_rst;
    ld_we   = s_we;
    ld_addr = a;
    ld_data = d;
    tick();
    start = 1'b0;
    rst   = 1'b1;
    ld_we = 1'b0;
  endtask

  task automatic loadWord(input int a, input logic [14:0] w);
    shadow[a] = w;
    applyStimulus(1'b0, 1'b1, 1'b1, 4'(a), w);
  endtask

  task automatic loadNextAll();
    for (int a = 0; a < 16; a++) loadWord(a, mw(a * 3 + 1, OP_NEXT, 0, 0));
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 15'd0);
  endtask

  task automatic startRun();
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 15'd0);
  endtask

  task automatic pushRun(input int u);
    sb.push_back('{4'(u), shadow[u][14:10], 1'b1, 1'b0, 1'b0});
  endtask

  task automatic pushHalt(input int u);
    sb.push_back('{4'(u), 5'd0, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic pushFault(input int u);
    sb.push_back('{4'(u), 5'd0, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic pushIdle(input int u);
    sb.push_back('{4'(u), 5'd0, 1'b0, 1'b0, 1'b0});
  endtask

  // Compares one queued entry per cycle; leaves time at the last compared cycle.
  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({tag, ".upc"},    32'(upc),     32'(e.upc));
      checkOutput({tag, ".dp"},     32'(dp_ctrl), 32'(e.dp));
      checkOutput({tag, ".busy"},   32'(busy),    32'(e.busy));
      checkOutput({tag, ".halted"}, 32'(halted),  32'(e.halted));
      checkOutput({tag, ".fault"},  32'(fault),   32'(e.fault));
      if (sb.size() > 0) tick();
    end
  endtask

  initial begin
    start = 1'b0; cond = 4'd0; ld_we = 1'b0; ld_addr = 4'd0; ld_data = 15'd0;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    pushIdle(0);
    drain("reset");

    // Linear run through the wrap point
    loadNextAll();
    startRun();
    for (int i = 0; i < 16; i++) pushRun(i);
    for (int i = 0; i < 5; i++) pushRun(i);
    drain("wrap");
    doReset();
    loadWord(3, mw(21, OP_HALT, 0, 0));
    startRun();
    for (int i = 0; i < 4; i++) pushRun(i);
    pushHalt(3); pushHalt(3);
    drain("halt");

    // Conditional jumps in both senses
    doReset();
    loadNextAll();
    loadWord(1, mw(7, OP_JC, 2, 9));
    cond = 4'b0100;
    startRun();
    pushRun(0); pushRun(1); pushRun(9); pushRun(10);
    drain("jc_taken");
    doReset();
    cond = 4'b0000;
    startRun();
    pushRun(0); pushRun(1); pushRun(2); pushRun(3);
    drain("jc_fall");
    doReset();
    loadWord(1, mw(7, OP_JNC, 2, 9));
    cond = 4'b0100;
    startRun();
    pushRun(0); pushRun(1); pushRun(2);
    drain("jnc_fall");
    doReset();
    cond = 4'b0000;
    startRun();
    pushRun(0); pushRun(1); pushRun(9);
    drain("jnc_taken");

    // Call and return
    doReset();
    loadNextAll();
    loadWord(1, mw(9, OP_CALL, 0, 8));
    loadWord(8, mw(11, OP_RET, 0, 0));
    startRun();
    pushRun(0); pushRun(1); pushRun(8); pushRun(2); pushRun(3);
    drain("call_ret");

    // Stack overflow on the fifth nested call, then recovery
    doReset();
    loadNextAll();
    for (int a = 0; a < 5; a++) loadWord(a, mw(a + 2, OP_CALL, 0, a + 1));
    startRun();
    for (int i = 0; i < 5; i++) pushRun(i);
    pushFault(4); pushFault(4);
    drain("overflow");
    startRun();
    pushIdle(4); pushIdle(4);
    drain("fault_clear");
    startRun();
    pushRun(0); pushRun(1);
    drain("restart");

    // Return on empty stack and a reserved opcode
    doReset();
    loadNextAll();
    loadWord(0, mw(3, OP_RET, 0, 0));
    startRun();
    pushRun(0); pushFault(0);
    drain("ret_empty");
    doReset();
    loadNextAll();
    loadWord(2, mw(6, 4'd12, 0, 0));
    startRun();
    pushRun(0); pushRun(1); pushRun(2); pushFault(2); pushFault(2);
    drain("reserved");
    startRun();
    pushIdle(2);
    drain("res_clear");
    startRun();
    pushRun(0); pushRun(1);
    drain("res_restart");

    // Reset in the middle of a run
    doReset();
    loadNextAll();
    startRun();
    for (int i = 0; i < 6; i++) pushRun(i);
    drain("pre_rst");
    doReset();
    pushIdle(0); pushIdle(0);
    drain("mid_rst");

    // Loads during RUN and during reset must be dropped
    loadWord(12, mw(17, OP_HALT, 0, 0));
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd5, mw(31, OP_HALT, 3, 15));
    startRun();
    pushRun(0); pushRun(1); pushRun(2);
    drain("ld_pre");
    ld_we = 1'b1; ld_addr = 4'd10; ld_data = mw(31, OP_HALT, 3, 15);
    tick();
    ld_we = 1'b0;
    for (int i = 3; i < 13; i++) pushRun(i);
    pushHalt(12);
    drain("ld_readback");

`ifdef USEQ_LOOP_EN
    doReset();
    loadNextAll();
    loadWord(0, mw(2, OP_LDC, 0, 3));
    loadWord(1, mw(5, OP_NEXT, 0, 0));
    loadWord(2, mw(9, OP_DJNZ, 0, 1));
    loadWord(3, mw(13, OP_HALT, 0, 0));
    startRun();
    pushRun(0);
    for (int i = 0; i < 4; i++) begin
      pushRun(1); pushRun(2);
    end
    pushRun(3); pushHalt(3);
    drain("loop");
`else
    doReset();
    loadNextAll();
    loadWord(0, mw(2, OP_LDC, 0, 3));
    startRun();
    pushRun(0); pushFault(0);
    drain("ldc_off");
`endif

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
